// File: rtl/uart_rx_frame.sv
// uart_rx_frame: oversampling UART receiver, 8N1 by default.
// Define UART_RX_PARITY_EN to receive 8E1 frames with even-parity checking.
// Valid/strobe semantics: rx_data_ready, framing_error and parity_error are
// single-clock, mutually exclusive pulses, one at most per frame, registered
// one clock after the stop-bit mid-sample. rx_data changes only together
// with an rx_data_ready pulse; there is no back-pressure.
module uart_rx_frame #(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD_RATE  = 115200,
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_data_ready,
    output logic       framing_error,
    output logic       parity_error,
    output logic [2:0] o_dbg_state
);

    localparam int DIV = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int TW  = $clog2(OVERSAMPLE);
    localparam logic [CW-1:0] DIV_LAST  = CW'(DIV - 1);
    localparam logic [TW-1:0] HALF_LAST = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] FULL_LAST = TW'(OVERSAMPLE - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4,
        S_BREAK  = 3'd5
    } state_t;

    state_t          r_state;
    state_t          w_state_nx;
    logic            r_rx_meta;
    logic            r_rx_s;
    logic [CW-1:0]   r_baud_cnt;
    logic [TW-1:0]   r_tick_cnt;
    logic [2:0]      r_bit_cnt;
    logic [7:0]      r_shift;
    logic [7:0]      r_rx_data;
    logic            r_rx_data_ready;
    logic            r_framing_error;
    logic            r_parity_error;
    logic            w_tick;
    logic            w_half;
    logic            w_full;
    logic            w_restart;
    logic            w_clr_ticks;
    logic            w_shift_en;
    logic            w_ready;
    logic            w_ferr;
    logic            w_perr;
    logic            w_par_fault;

    assign w_tick = (r_baud_cnt == DIV_LAST);
    assign w_half = w_tick && (r_tick_cnt == HALF_LAST);
    assign w_full = w_tick && (r_tick_cnt == FULL_LAST);

`ifdef UART_RX_PARITY_EN
    logic r_par_bit;
    logic w_par_en;
    assign w_par_fault = ((^r_shift) != r_par_bit);
`else
    assign w_par_fault = 1'b0;
`endif

    // Two-flop synchroniser for the asynchronous serial line (idles high)
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
        end else begin
            r_rx_meta <= rx;
            r_rx_s    <= r_rx_meta;
        end
    end

    // Baud divider: free-runs, re-phased to the start edge of each frame
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_baud_cnt <= '0;
        end else if (w_restart || w_tick) begin
            r_baud_cnt <= '0;
        end else begin
            r_baud_cnt <= r_baud_cnt + 1'b1;
        end
    end

    // Tick counter locating the mid-bit sample point within the current bit
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_tick_cnt <= '0;
        end else if (w_clr_ticks) begin
            r_tick_cnt <= '0;
        end else if (w_tick) begin
            r_tick_cnt <= r_tick_cnt + 1'b1;
        end
    end

    // Data shift register (LSB first) and received-bit counter
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_shift   <= '0;
            r_bit_cnt <= '0;
        end else if (w_restart) begin
            r_bit_cnt <= '0;
        end else if (w_shift_en) begin
            r_shift   <= {r_rx_s, r_shift[7:1]};
            r_bit_cnt <= r_bit_cnt + 1'b1;
        end
    end

`ifdef UART_RX_PARITY_EN
    // Captured parity bit, compared against the data once the stop bit is seen
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_par_bit <= 1'b0;
        end else if (w_par_en) begin
            r_par_bit <= r_rx_s;
        end
    end
`endif

    // FSM state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    // FSM next-state and per-sample control decode
    always_comb begin
        w_state_nx  = r_state;
        w_restart   = 1'b0;
        w_clr_ticks = 1'b0;
        w_shift_en  = 1'b0;
        w_ready     = 1'b0;
        w_ferr      = 1'b0;
        w_perr      = 1'b0;
`ifdef UART_RX_PARITY_EN
        w_par_en    = 1'b0;
`endif
        case (r_state)
            S_IDLE: begin
                if (!r_rx_s) begin
                    w_restart   = 1'b1;
                    w_clr_ticks = 1'b1;
                    w_state_nx  = S_START;
                end
            end
            S_START: begin
                if (w_half) begin
                    w_clr_ticks = 1'b1;
                    w_state_nx  = r_rx_s ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (w_full) begin
                    w_shift_en  = 1'b1;
                    w_clr_ticks = 1'b1;
                    if (r_bit_cnt == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        w_state_nx = S_PARITY;
`else
                        w_state_nx = S_STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (w_full) begin
                    w_par_en    = 1'b1;
                    w_clr_ticks = 1'b1;
                    w_state_nx  = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (w_full) begin
                    w_clr_ticks = 1'b1;
                    if (!r_rx_s) begin
                        w_ferr     = 1'b1;
                        w_state_nx = S_BREAK;
                    end else begin
                        w_perr     = w_par_fault;
                        w_ready    = !w_par_fault;
                        w_state_nx = S_IDLE;
                    end
                end
            end
            S_BREAK: begin
                if (r_rx_s) begin
                    w_state_nx = S_IDLE;
                end
            end
            default: begin
                w_state_nx = S_IDLE;
            end
        endcase
    end

    // Registered output strobes and the held received byte
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rx_data       <= 8'h00;
            r_rx_data_ready <= 1'b0;
            r_framing_error <= 1'b0;
            r_parity_error  <= 1'b0;
        end else begin
            r_rx_data_ready <= w_ready;
            r_framing_error <= w_ferr;
            r_parity_error  <= w_perr;
            if (w_ready) begin
                r_rx_data <= r_shift;
            end
        end
    end

    assign rx_data       = r_rx_data;
    assign rx_data_ready = r_rx_data_ready;
    assign framing_error = r_framing_error;
    assign parity_error  = r_parity_error;
    assign o_dbg_state   = r_state;

endmodule
